// File: rtl/alu_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package alu_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dq_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] next_rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, dq_msb_i};
        // Subtract as add of the inverted divisor with carry-in, like the arithmetic unit.
        trial   = shifted + {1'b1, ~d_i} + {{WIDTH{1'b0}}, 1'b1};
        q_bit_o = ~trial[WIDTH];
        // The running remainder stays below the divisor, so its top bit is always zero.
        next_rem_o = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module alu_divider_seq
    import alu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DivZero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i      (rem_q),
        .dq_msb_i   (dq_q[WIDTH-1]),
        .d_i        (d_q),
        .next_rem_o (step_rem),
        .q_bit_o    (step_q)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (B == '0) begin
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        rem_d   = '0;
                        dq_d    = A;
                        d_d     = B;
                        cnt_d   = CntW'(WIDTH - 1);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d = step_rem;
                dq_d  = {dq_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // Result registers load on the final step so outputs only move on DONE entry.
                    q_d     = {dq_q[WIDTH-2:0], step_q};
                    r_d     = step_rem;
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            dq_q    <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;

endmodule
